// File: rtl/add_stream_ctrl_if.sv
// Operand and result handshake channels of add_stream_ctrl.
// The slave view belongs to the controller; the master view belongs to its environment.
interface add_stream_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_a;
  logic [31:0] s_b;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_res;
  logic        m_ovfl;

  modport slave (
    input  s_valid, s_a, s_b, m_ready,
    output s_ready, m_valid, m_res, m_ovfl
  );

  modport master (
    output s_valid, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_res, m_ovfl
  );
endinterface

// File: rtl/add_stream_ctrl.sv
// Credit-based controller around an external one-cycle registered adder.
// Results are queued in order, and carry-outs are counted with saturation.
module add_stream_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  add_stream_ctrl_if.slave   bus,
  output logic [31:0]        add_ina_o,
  output logic [31:0]        add_inb_o,
  input  logic [31:0]        add_res_i,
  input  logic               add_ovfl_i,
  input  logic               clr_cnt_i,
  output logic [CNT_W-1:0]   ovfl_cnt_o,
  output logic               busy_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic              inflight_q, inflight_d;
  logic [AW:0]       count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [32:0]       mem_q [DEPTH];

  logic              s_ready;
  logic              m_valid;
  logic              accept;
  logic              push;
  logic              pop;
  logic [AW+1:0]     credit;

  // An operation in flight already owns a FIFO slot, so it is counted as a used credit.
  assign credit  = {1'b0, count_q} + {{(AW+1){1'b0}}, inflight_q};
  assign s_ready = credit < {1'b0, DEPTH_C};
  assign m_valid = (count_q != '0);
  assign accept  = bus.s_valid && s_ready;
  assign push    = inflight_q;
  assign pop     = m_valid && bus.m_ready;

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_res   = m_valid ? mem_q[rd_ptr_q][31:0] : 32'h0;
  assign bus.m_ovfl  = m_valid ? mem_q[rd_ptr_q][32] : 1'b0;

  assign add_ina_o  = accept ? bus.s_a : 32'h0;
  assign add_inb_o  = accept ? bus.s_b : 32'h0;
  assign ovfl_cnt_o = cnt_q;
  assign busy_o     = inflight_q || m_valid;

  always_comb begin
    inflight_d = accept;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Clear wins over a same-cycle increment; the counter sticks at all-ones.
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (push && add_ovfl_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {add_ovfl_i, add_res_i};
    end
  end

  no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(inflight_q && (count_q == DEPTH_C))
  );

endmodule

// File: doc/add_stream_ctrl.md
ADD_STREAM_CTRL -- requirements
Module: add_stream_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, result FIFO entries; power of two, 2..16.
REQ-002 Parameter CNT_W, default 16, width of overflow event counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  operand pair valid.
REQ-006 s_ready  output  1  block accepts operand pair.
REQ-007 s_a  input  32  operand A.
REQ-008 s_b  input  32  operand B.
REQ-009 add_ina  output  32  operand A to registered adder stage.
REQ-010 add_inb  output  32  operand B to registered adder stage.
REQ-011 add_res  input  32  registered sum from adder stage, valid one cycle after issue.
REQ-012 add_ovfl  input  1  registered carry-out from adder stage, aligned with add_res.
REQ-013 m_valid  output  1  result available.
REQ-014 m_ready  input  1  downstream accepts result.
REQ-015 m_res  output  32  result sum at FIFO head.
REQ-016 m_ovfl  output  1  carry-out at FIFO head.
REQ-017 clr_cnt  input  1  synchronous clear of ovfl_cnt.
REQ-018 ovfl_cnt  output  CNT_W  count of captured results with carry-out set.
REQ-019 busy  output  1  operation in flight or FIFO non-empty.

Function
REQ-020 Accept: s_valid && s_ready at rising edge; exactly one operand pair issued per accept.
REQ-021 add_ina/add_inb = s_a/s_b combinationally while s_valid && s_ready; 32'h0 otherwise.
REQ-022 inflight flag: set on accept edge, cleared on next edge unless a new accept occurs on that edge (then stays 1).
REQ-023 Capture: on edge where inflight==1, {add_ovfl, add_res} pushed into FIFO tail.
REQ-024 Latency: pair accepted at edge N -> m_valid high after edge N+1 if FIFO was empty; no bypass path.
REQ-025 s_ready = (fifo_count + inflight) < DEPTH; s_ready has no combinational dependence on m_ready or s_valid.
REQ-026 Credit rule guarantees no push into a full FIFO; push when full is unreachable and is an assertion failure.
REQ-027 m_valid = (fifo_count != 0); m_res/m_ovfl driven from head entry, stable while m_valid && !m_ready.
REQ-028 Pop: m_valid && m_ready at edge; head pointer advances modulo DEPTH.
REQ-029 Simultaneous push and pop: count unchanged, both pointers advance; valid also when count==DEPTH-1 or 1.
REQ-030 Results leave in strict acceptance order.
REQ-031 Sustained throughput one result/cycle when m_ready held high (steady state count<=1, inflight=1).
REQ-032 ovfl_cnt increments by 1 on each capture with add_ovfl==1; saturates at all-ones.
REQ-033 clr_cnt has priority: clr_cnt && increment in same cycle -> ovfl_cnt = 0.
REQ-034 busy = inflight || (fifo_count != 0).

Reset
REQ-035 rst_n low: inflight=0, fifo_count=0, pointers=0, ovfl_cnt=0, m_valid=0, s_ready=1, busy=0, add_ina/add_inb=0, m_res=0, m_ovfl=0.
REQ-036 Reset mid-operation discards in-flight op and all FIFO contents; adder stage is reset by the same rst_n, so no stale result is captured after release.
REQ-037 First accept permitted on first rising edge after rst_n deasserts.

Verification
REQ-038 Accept 5+7, m_ready=1 -> m_valid two edges later, m_res=12, m_ovfl=0, ovfl_cnt=0.
REQ-039 Accept 32'hFFFFFFFF+32'h1 -> m_res=0, m_ovfl=1, ovfl_cnt=1.
REQ-040 m_ready=0, offer 6 pairs (i+i, i=1..6) -> exactly 4 accepted, s_ready=0; release m_ready -> results 2,4,6,8 then 10,12 in order.
REQ-041 100 random back-to-back pairs, m_ready=1 -> one accept per cycle, no s_ready drop, all sums match reference model.
REQ-042 Force ovfl_cnt to all-ones via overflow stream -> stays all-ones; clr_cnt with concurrent overflow capture -> 0.
REQ-043 3 entries in FIFO plus one in flight, pulse rst_n low -> m_valid=0, busy=0, s_ready=1, no result emerges after release.
